// File: rtl/pass_verify_if.sv
// Password-check bus between the requester/password store and pass_verify.
// The master drives the request and the store read data; the slave returns status.
interface pass_verify_if;
  logic        check;
  logic [15:0] pin_in;
  logic [16:0] slot_data;
  logic [1:0]  read_addr;
  logic        busy;
  logic        match;
  logic        fail;
  logic [1:0]  match_slot;
  logic        locked;
  logic [2:0]  fail_cnt;

  modport master (
    output check, pin_in, slot_data,
    input  read_addr, busy, match, fail, match_slot, locked, fail_cnt
  );

  modport slave (
    input  check, pin_in, slot_data,
    output read_addr, busy, match, fail, match_slot, locked, fail_cnt
  );
endinterface

// File: rtl/pass_verify.sv
// Password verifier: scans a three-slot password store, reports match/fail and
// counts consecutive failures. Lockout is built only when PASS_VERIFY_LOCKOUT_EN is defined.
module pass_verify #(
  parameter int unsigned MAX_FAILS   = 3,
  parameter int unsigned LOCK_CYCLES = 1000
) (
  input logic          clk,
  input logic          reset,
  pass_verify_if.slave bus
);

  if (MAX_FAILS < 1 || MAX_FAILS > 7) begin : gen_bad_max_fails
    $error("pass_verify: MAX_FAILS must be in 1..7");
  end
  if (LOCK_CYCLES < 1 || LOCK_CYCLES > 65535) begin : gen_bad_lock_cycles
    $error("pass_verify: LOCK_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {
    StIdle,
    StScan,
`ifdef PASS_VERIFY_LOCKOUT_EN
    StDone,
    StLock
`else
    StDone
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  addr_q, addr_d;
  logic [15:0] pin_q, pin_d;
  logic        match_q, match_d;
  logic        fail_q, fail_d;
  logic [1:0]  slot_q, slot_d;
  logic [2:0]  fail_cnt_q, fail_cnt_d;
`ifdef PASS_VERIFY_LOCKOUT_EN
  logic [15:0] lock_cnt_q, lock_cnt_d;
`endif

  logic hit;
  assign hit = bus.slot_data[16] && (bus.slot_data[15:0] == pin_q);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pin_d      = pin_q;
    match_d    = 1'b0;
    fail_d     = 1'b0;
    slot_d     = slot_q;
    fail_cnt_d = fail_cnt_q;
`ifdef PASS_VERIFY_LOCKOUT_EN
    lock_cnt_d = lock_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        addr_d = 2'd0;
        if (bus.check) begin
          pin_d   = bus.pin_in;
          state_d = StScan;
        end
      end
      StScan: begin
        // Slots are visited in ascending order, so the first hit is the lowest index.
        if (hit) begin
          match_d    = 1'b1;
          slot_d     = addr_q;
          fail_cnt_d = 3'd0;
          addr_d     = 2'd0;
          state_d    = StDone;
        end else if (addr_q == 2'd2) begin
          fail_d     = 1'b1;
          fail_cnt_d = (fail_cnt_q == 3'd7) ? 3'd7 : fail_cnt_q + 3'd1;
          addr_d     = 2'd0;
          state_d    = StDone;
        end else begin
          addr_d = addr_q + 2'd1;
        end
      end
      StDone: begin
`ifdef PASS_VERIFY_LOCKOUT_EN
        if (fail_q && (fail_cnt_q == 3'(MAX_FAILS))) begin
          lock_cnt_d = 16'(LOCK_CYCLES);
          state_d    = StLock;
        end else begin
          state_d = StIdle;
        end
`else
        state_d = StIdle;
`endif
      end
`ifdef PASS_VERIFY_LOCKOUT_EN
      StLock: begin
        // Counter holds the remaining lock cycles including the current one.
        if (lock_cnt_q <= 16'd1) begin
          lock_cnt_d = 16'd0;
          fail_cnt_d = 3'd0;
          state_d    = StIdle;
        end else begin
          lock_cnt_d = lock_cnt_q - 16'd1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= 2'd0;
      pin_q      <= 16'd0;
      match_q    <= 1'b0;
      fail_q     <= 1'b0;
      slot_q     <= 2'd0;
      fail_cnt_q <= 3'd0;
`ifdef PASS_VERIFY_LOCKOUT_EN
      lock_cnt_q <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pin_q      <= pin_d;
      match_q    <= match_d;
      fail_q     <= fail_d;
      slot_q     <= slot_d;
      fail_cnt_q <= fail_cnt_d;
`ifdef PASS_VERIFY_LOCKOUT_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  assign bus.read_addr  = addr_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.match      = match_q;
  assign bus.fail       = fail_q;
  assign bus.match_slot = slot_q;
  assign bus.fail_cnt   = fail_cnt_q;
`ifdef PASS_VERIFY_LOCKOUT_EN
  assign bus.locked     = (state_q == StLock);
`else
  assign bus.locked     = 1'b0;
`endif

endmodule

// File: tb/tb_pass_verify.sv
// Self-checking bench for pass_verify: directed cases plus random stores/pins
// checked against a slot-search reference model.
module tb_pass_verify;
  localparam int unsigned MaxFails   = 3;
  localparam int unsigned LockCycles = 10;
`ifdef PASS_VERIFY_LOCKOUT_EN
  localparam bit Lockout = 1'b1;
`else
  localparam bit Lockout = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [16:0] store [4];
  int          checks = 0;
  int          errors = 0;
  int          m_cnt  = 0;
  logic [1:0]  m_slot = 2'd0;

  pass_verify_if bus ();

  pass_verify #(
    .MAX_FAILS  (MaxFails),
    .LOCK_CYCLES(LockCycles)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  assign bus.slot_data = store[bus.read_addr];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " read_addr"}, bus.read_addr, 0);
    chk({tag, " busy"}, bus.busy, 0);
    chk({tag, " match"}, bus.match, 0);
    chk({tag, " fail"}, bus.fail, 0);
    chk({tag, " match_slot"}, bus.match_slot, 0);
    chk({tag, " locked"}, bus.locked, 0);
    chk({tag, " fail_cnt"}, bus.fail_cnt, 0);
  endtask

  // Entered while IDLE, #1 after a rising edge. Optionally rewrites slot 2 mid-scan.
  task automatic do_check(input string tag, input logic [15:0] pin, input bit mut,
                          input logic [16:0] mut_val);
    int hit;
    int lat;
    bit lock_exp;
    bus.check  = 1'b1;
    bus.pin_in = pin;
    @(posedge clk); #1;
    bus.check  = 1'b0;
    bus.pin_in = 16'($urandom);
    if (mut) store[2] = mut_val;
    hit = -1;
    for (int i = 0; i < 3; i++)
      if (hit < 0 && store[i][16] && store[i][15:0] == pin) hit = i;
    lat = (hit >= 0) ? hit + 1 : 3;
    chk({tag, " busy after accept"}, bus.busy, 1);
    for (int c = 1; c <= lat; c++) begin
      chk({tag, " no early pulse"}, {bus.match, bus.fail}, 0);
      @(posedge clk); #1;
    end
    if (hit >= 0) begin
      m_cnt  = 0;
      m_slot = 2'(hit);
    end else begin
      m_cnt = (m_cnt == 7) ? 7 : m_cnt + 1;
    end
    lock_exp = Lockout && (hit < 0) && (m_cnt == MaxFails);
    chk({tag, " match"}, bus.match, hit >= 0);
    chk({tag, " fail"}, bus.fail, hit < 0);
    chk({tag, " match_slot"}, bus.match_slot, m_slot);
    chk({tag, " fail_cnt"}, bus.fail_cnt, m_cnt);
    chk({tag, " busy in done"}, bus.busy, 1);
    @(posedge clk); #1;
    chk({tag, " pulse one cycle"}, {bus.match, bus.fail}, 0);
    if (lock_exp) begin
      for (int c = 0; c < LockCycles; c++) begin
        chk({tag, " locked"}, bus.locked, 1);
        chk({tag, " busy while locked"}, bus.busy, 1);
        if (c == 2) begin
          bus.check  = 1'b1;
          bus.pin_in = store[0][15:0];
        end
        if (c == 4) bus.check = 1'b0;
        @(posedge clk); #1;
      end
      m_cnt = 0;
      @(posedge clk); #1;
      chk({tag, " check during lock ignored"}, bus.busy, 0);
    end
    chk({tag, " busy after done"}, bus.busy, 0);
    chk({tag, " locked after"}, bus.locked, 0);
    chk({tag, " fail_cnt after"}, bus.fail_cnt, m_cnt);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) store[i] = 17'd0;
    bus.check  = 1'b0;
    bus.pin_in = 16'd0;
    #2;
    chk_reset_vals("reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;

    store[0] = {1'b1, 16'h1234};
    do_check("slot0 hit", 16'h1234, 1'b0, 17'd0);

    store[0] = 17'd0;
    store[2] = {1'b1, 16'hBEEF};
    do_check("slot2 hit", 16'hBEEF, 1'b0, 17'd0);
    store[2] = {1'b0, 16'hBEEF};
    do_check("slot2 invalid", 16'hBEEF, 1'b0, 17'd0);

    store[0] = {1'b1, 16'h0AAA};
    store[1] = {1'b1, 16'h5555};
    store[2] = {1'b1, 16'h5555};
    do_check("lowest hit", 16'h5555, 1'b0, 17'd0);

    store[0] = 17'd0;
    store[1] = 17'd0;
    store[2] = {1'b1, 16'h7777};
    do_check("mid-scan invalidate", 16'h7777, 1'b1, {1'b0, 16'h7777});
    do_check("mid-scan validate", 16'h6666, 1'b1, {1'b1, 16'h6666});

    store[2] = 17'd0;
    do_check("empty store", 16'h0000, 1'b0, 17'd0);

    store[0] = {1'b1, 16'hC0DE};
    do_check("clear count", 16'hC0DE, 1'b0, 17'd0);
    for (int n = 0; n < 8; n++) do_check("wrong pin", 16'hDEAD, 1'b0, 17'd0);
    do_check("right after fails", 16'hC0DE, 1'b0, 17'd0);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 3; i++)
        store[i] = {1'($urandom_range(0, 1)), 16'h1000 + 16'($urandom_range(0, 3))};
      do_check("random", 16'h1000 + 16'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
               {1'($urandom_range(0, 1)), 16'h1000 + 16'($urandom_range(0, 3))});
    end

    store[0] = 17'd0;
    store[1] = 17'd0;
    store[2] = {1'b1, 16'hA5A5};
    bus.check  = 1'b1;
    bus.pin_in = 16'hA5A5;
    @(posedge clk); #1;
    bus.check = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk_reset_vals("reset mid-scan");
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("no pulse after abort", {bus.match, bus.fail}, 0);
    end
    reset  = 1'b0;
    m_cnt  = 0;
    m_slot = 2'd0;
    @(posedge clk); #1;
    do_check("after reset", 16'hA5A5, 1'b0, 17'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pass_verify.md
PASS_VERIFY -- requirements
Module: pass_verify

Interface
REQ-001: Parameter MAX_FAILS, default 3, number of consecutive failed checks that triggers lockout (range 1..7).
REQ-002: Parameter LOCK_CYCLES, default 1000, lockout duration in clk cycles (range 1..65535).
REQ-003: clk  input  1  system clock; all state updates on its rising edge.
REQ-004: reset  input  1  reset, asynchronous, active-high.
REQ-005: check  input  1  level sampled each cycle; high in IDLE requests a password check.
REQ-006: pin_in  input  16  entered password; sampled only on the accepting cycle.
REQ-007: slot_data  input  17  password-store read data for read_addr; bit 16 = valid, bits 15:0 = password; combinational in the same cycle.
REQ-008: read_addr  output  2  password-store read address; only 00, 01, 10 are ever driven.
REQ-009: busy  output  1  high from the accepting edge until the FSM returns to IDLE.
REQ-010: match  output  1  one-cycle pulse: entered password equals a valid stored slot.
REQ-011: fail  output  1  one-cycle pulse: no valid slot matched.
REQ-012: match_slot  output  2  slot index of the last match; held until the next match or reset.
REQ-013: locked  output  1  high while lockout is active.
REQ-014: fail_cnt  output  3  consecutive-failure count.

Function
REQ-015: FSM states are IDLE, SCAN, DONE, LOCK; reset state is IDLE.
REQ-016: IDLE: read_addr = 00; if check = 1 and not locked, latch pin_in, set read_addr to 00, enter SCAN.
REQ-017: SCAN: one slot per cycle, in order 00, 01, 10; a slot hits when slot_data[16] = 1 and slot_data[15:0] equals the latched pin.
REQ-018: SCAN hit: on the next edge enter DONE with match = 1 and match_slot = current read_addr; the lowest-index hit wins.
REQ-019: SCAN miss at 00/01: increment read_addr and stay in SCAN. Miss at 10: enter DONE with fail = 1.
REQ-020: Latency: the result pulse is in cycle N+1 after the accepting edge for a hit at slot N; a fail pulse is in cycle 3.
REQ-021: DONE lasts one cycle. It then enters LOCK if fail_cnt has just reached MAX_FAILS, else IDLE; busy drops on that edge.
REQ-022: fail_cnt increments on each fail, saturates at 7, and clears to 0 on any match.
REQ-023: check is ignored while busy or locked; it is not queued.
REQ-024: pin_in changes during SCAN have no effect; the latched value is used.
REQ-025: An empty store (all valid bits 0) yields fail.
REQ-026: Slot data is re-evaluated each SCAN cycle. A store change during a scan affects only slots not yet read.
REQ-027: LOCK: locked = 1 and busy = 1; a 16-bit down-counter loaded with LOCK_CYCLES runs. At zero, clear fail_cnt and locked and enter IDLE.

Reset
REQ-028: Reset asserted in any state, including mid-SCAN or LOCK, forces IDLE immediately.
REQ-029: Reset values: read_addr = 00, busy = 0, match = 0, fail = 0, match_slot = 00, locked = 0, fail_cnt = 0, lock counter = 0, latched pin = 0.
REQ-030: No match or fail pulse shall be emitted for a check aborted by reset.

Configuration
REQ-031: Macro PASS_VERIFY_LOCKOUT_EN defined: the LOCK state and lock counter are implemented per REQ-021 and REQ-027.
REQ-032: Macro PASS_VERIFY_LOCKOUT_EN undefined: no LOCK state or lock counter; locked is tied to 0; DONE always returns to IDLE; fail_cnt still counts and saturates per REQ-022.

Verification
REQ-033: Store slot00 = {1,0x1234}, check with pin 0x1234 -> match pulse in cycle 1, match_slot = 00, fail_cnt = 0, busy low after DONE.
REQ-034: Store slot10 = {1,0xBEEF}, slots 00/01 invalid, pin 0xBEEF -> match in cycle 3, match_slot = 10; the same pin with slot10 valid bit 0 -> fail in cycle 3.
REQ-035: Slot01 and slot10 both hold 0x5555 (valid), pin 0x5555 -> match_slot = 01, single match pulse.
REQ-036: LOCKOUT_EN, MAX_FAILS = 3, LOCK_CYCLES = 10, three wrong pins -> fail_cnt 1, 2, 3; locked high for 10 cycles; a check during lock is ignored; then fail_cnt = 0 and locked = 0.
REQ-037: Assert reset in SCAN cycle 2 -> all outputs at reset values the same cycle, no match or fail pulse; a subsequent check works normally.
REQ-038: Without LOCKOUT_EN, 8 wrong pins -> fail_cnt saturates at 7, locked stays 0; a correct pin then gives match and fail_cnt = 0.
